mw_wb_stage: RTL and testbench
==============================

# mw_wb_stage

M/W pipeline register plus write-back data selector for the five-stage MIPS pipeline. Captures the memory-stage result bundle on each clock edge, extends sub-word load data, selects the final write-back value, and drives the register file's write port (RegWrite, WA, WD, PC). Its outputs also serve as the W-stage forwarding source for the D and E stages.

## Interface
- RESET_PC, 32'h0000_0000, value of w_pc after reset or flush
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high; highest priority
- en  in  1  capture enable; 0 = hold (stall)
- flush  in  1  insert bubble on next edge
- m_pc  in  32  PC of instruction in M stage
- m_reg_write  in  1  instruction writes a GPR
- m_wa  in  5  destination register number
- m_wd_sel  in  3  write-back source: 0 ALU, 1 MEM, 2 PC+8, 3 HI/LO, 4 CP0, 5–7 reserved
- m_alu_out  in  32  ALU result / effective address
- m_mem_rdata  in  32  raw word from data memory
- m_hilo  in  32  HI or LO value (mfhi/mflo)
- m_cp0_rdata  in  32  CP0 read value (mfc0)
- m_load_type  in  3  0 lw, 1 lbu, 2 lb, 3 lhu, 4 lh, 5–7 treated as lw
- w_reg_write  out  1  write enable to register file
- w_wa  out  5  write address
- w_wd  out  32  write data
- w_pc  out  32  PC of W-stage instruction (trace/debug)
- w_valid  out  1  W stage holds a real instruction (not a bubble)

## Operation
- Registered fields: pc, reg_write, wa, wd_sel, alu_out, mem_rdata, hilo, cp0_rdata, load_type, valid. Extension and selection are combinational on the registered fields.
- Edge priority: reset > flush > !en (hold all) > capture.
- Capture: all fields take M inputs; valid <= 1.
- Reset/flush: reg_write 0, wa 0, wd_sel 0, all data fields 0, load_type 0, valid 0, pc <= RESET_PC.
- w_reg_write = reg_write && (wa != 0); a write to $0 never asserts the port.
- w_wa = wa, regardless of w_reg_write.
- Write data:
  - sel 0: alu_out.
  - sel 1: load-extended mem_rdata.
  - sel 2: pc + 8, 32-bit modulo add, wraps at 2^32.
  - sel 3: hilo.
  - sel 4: cp0_rdata.
  - sel 5–7: 32'h0.
- Load extension uses alu_out[1:0] as byte offset, little-endian:
  - Byte k = mem_rdata[8k+7:8k].
  - lbu zero-extends, lb sign-extends from bit 7 of the selected byte.
  - Halfword = mem_rdata[31:16] if alu_out[1], else [15:0]; alu_out[0] ignored (misalignment trapped upstream). lhu zero-extends, lh sign-extends from bit 15.
  - lw passes mem_rdata unchanged.

## Timing
- Latency 1: M inputs present before edge N appear on outputs after edge N.
- w_wd is combinational from registers only, never from M inputs; no combinational path M → W.
- Reset values of all outputs: w_reg_write 0, w_wa 0, w_wd 0, w_pc RESET_PC, w_valid 0.
- Stall (en=0): outputs unchanged for every held cycle, including w_reg_write. The register file rewrites the same value, which is harmless.
- flush and en=0 in the same cycle: flush wins and a bubble is inserted.
- Reset asserted mid-stall or mid-flush: reset values on the next edge.

## Configuration
- SUBWORD_LOAD_EN defined: load extension as described.
- SUBWORD_LOAD_EN undefined: m_load_type is not registered and is ignored; sel 1 always yields raw mem_rdata (lw behaviour); all other behaviour is identical.

## Test plan
- Reset: assert reset 2 cycles with arbitrary inputs → w_reg_write 0, w_wa 0, w_wd 0, w_pc RESET_PC, w_valid 0.
- ALU and link:
  - m_reg_write 1, m_wa 5, sel 0, alu_out 32'h1234_5678, m_pc 32'h3000 → next cycle w_reg_write 1, w_wa 5, w_wd 32'h1234_5678, w_pc 32'h3000.
  - Then sel 2, wa 31, m_pc 32'hFFFF_FFFC → w_wd 32'h0000_0004 (wrap).
- Loads (macro defined), mem_rdata 32'h80FF_7F01:
  - lb, offset 3 → w_wd 32'hFFFF_FF80.
  - lbu, offset 2 → 32'h0000_00FF.
  - lh, offset 2 → 32'hFFFF_80FF.
  - lhu, offset 0 → 32'h0000_7F01.
  - Macro undefined, same lb stimulus → w_wd 32'h80FF_7F01.
- $0 suppression: m_reg_write 1, m_wa 0, sel 0, alu_out 32'hDEAD_BEEF → w_reg_write 0, w_wa 0, w_wd 32'hDEAD_BEEF.
- Stall then flush:
  - Capture wa 7; en 0 for 3 cycles with changing inputs → outputs frozen.
  - Then flush 1 with en 0 → next cycle w_reg_write 0, w_valid 0, w_pc RESET_PC.
- Reserved select: sel 6, hilo 32'h1, cp0 32'h2 → w_wd 32'h0.

Source files
------------

// File: rtl/mw_wb_stage.sv
// M/W pipeline register and write-back selector; drives the register-file write port.
// Optional macro SUBWORD_LOAD_EN enables byte/halfword load extension.
module mw_wb_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        flush,
  input  logic [31:0] m_pc,
  input  logic        m_reg_write,
  input  logic [4:0]  m_wa,
  input  logic [2:0]  m_wd_sel,
  input  logic [31:0] m_alu_out,
  input  logic [31:0] m_mem_rdata,
  input  logic [31:0] m_hilo,
  input  logic [31:0] m_cp0_rdata,
  input  logic [2:0]  m_load_type,
  output logic        w_reg_write,
  output logic [4:0]  w_wa,
  output logic [31:0] w_wd,
  output logic [31:0] w_pc,
  output logic        w_valid
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned SW   = 3;

  localparam logic [SW-1:0] SEL_ALU  = 3'd0;
  localparam logic [SW-1:0] SEL_MEM  = 3'd1;
  localparam logic [SW-1:0] SEL_LINK = 3'd2;
  localparam logic [SW-1:0] SEL_HILO = 3'd3;
  localparam logic [SW-1:0] SEL_CP0  = 3'd4;

  logic [XLEN-1:0] pc_q;
  logic            reg_write_q;
  logic [AW-1:0]   wa_q;
  logic [SW-1:0]   wd_sel_q;
  logic [XLEN-1:0] alu_out_q;
  logic [XLEN-1:0] mem_rdata_q;
  logic [XLEN-1:0] hilo_q;
  logic [XLEN-1:0] cp0_rdata_q;
  logic            valid_q;
  logic [XLEN-1:0] load_data;

`ifdef SUBWORD_LOAD_EN
  localparam logic [SW-1:0] LD_LBU = 3'd1;
  localparam logic [SW-1:0] LD_LB  = 3'd2;
  localparam logic [SW-1:0] LD_LHU = 3'd3;
  localparam logic [SW-1:0] LD_LH  = 3'd4;

  logic [SW-1:0] load_type_q;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      load_type_q <= '0;
    end else if (en) begin
      load_type_q <= m_load_type;
    end
  end

  // Little-endian lane pick from the registered effective address.
  always_comb begin
    ld_byte   = 8'h00;
    ld_half   = alu_out_q[1] ? mem_rdata_q[31:16] : mem_rdata_q[15:0];
    load_data = mem_rdata_q;
    case (alu_out_q[1:0])
      2'd0:    ld_byte = mem_rdata_q[7:0];
      2'd1:    ld_byte = mem_rdata_q[15:8];
      2'd2:    ld_byte = mem_rdata_q[23:16];
      default: ld_byte = mem_rdata_q[31:24];
    endcase
    case (load_type_q)
      LD_LBU:  load_data = {24'h000000, ld_byte};
      LD_LB:   load_data = {{24{ld_byte[7]}}, ld_byte};
      LD_LHU:  load_data = {16'h0000, ld_half};
      LD_LH:   load_data = {{16{ld_half[15]}}, ld_half};
      default: load_data = mem_rdata_q;
    endcase
  end
`else
  logic unused_load_type;
  assign unused_load_type = ^m_load_type;

  always_comb begin
    load_data = mem_rdata_q;
  end
`endif

  // Pipeline register: reset > flush > hold > capture.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      pc_q        <= RESET_PC;
      reg_write_q <= 1'b0;
      wa_q        <= '0;
      wd_sel_q    <= '0;
      alu_out_q   <= '0;
      mem_rdata_q <= '0;
      hilo_q      <= '0;
      cp0_rdata_q <= '0;
      valid_q     <= 1'b0;
    end else if (en) begin
      pc_q        <= m_pc;
      reg_write_q <= m_reg_write;
      wa_q        <= m_wa;
      wd_sel_q    <= m_wd_sel;
      alu_out_q   <= m_alu_out;
      mem_rdata_q <= m_mem_rdata;
      hilo_q      <= m_hilo;
      cp0_rdata_q <= m_cp0_rdata;
      valid_q     <= 1'b1;
    end
  end

  // Write-back source select; reserved encodings yield zero.
  always_comb begin
    w_wd = '0;
    case (wd_sel_q)
      SEL_ALU:  w_wd = alu_out_q;
      SEL_MEM:  w_wd = load_data;
      SEL_LINK: w_wd = XLEN'(pc_q + 32'd8);
      SEL_HILO: w_wd = hilo_q;
      SEL_CP0:  w_wd = cp0_rdata_q;
      default:  w_wd = '0;
    endcase
  end

  assign w_reg_write = reg_write_q && (wa_q != '0);
  assign w_wa        = wa_q;
  assign w_pc        = pc_q;
  assign w_valid     = valid_q;

endmodule

// File: tb/tb_mw_wb_stage.sv
// Directed self-checking bench for mw_wb_stage (define SUBWORD_LOAD_EN for the load-extension build).
module tb_mw_wb_stage;

  logic        clk = 1'b0;
  logic        reset, en, flush;
  logic [31:0] m_pc, m_alu_out, m_mem_rdata, m_hilo, m_cp0_rdata;
  logic        m_reg_write;
  logic [4:0]  m_wa;
  logic [2:0]  m_wd_sel, m_load_type;
  logic        w_reg_write, w_valid;
  logic [4:0]  w_wa;
  logic [31:0] w_wd, w_pc;

  int checks = 0;
  int errors = 0;

  mw_wb_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .m_pc(m_pc), .m_reg_write(m_reg_write), .m_wa(m_wa), .m_wd_sel(m_wd_sel),
    .m_alu_out(m_alu_out), .m_mem_rdata(m_mem_rdata), .m_hilo(m_hilo),
    .m_cp0_rdata(m_cp0_rdata), .m_load_type(m_load_type),
    .w_reg_write(w_reg_write), .w_wa(w_wa), .w_wd(w_wd), .w_pc(w_pc), .w_valid(w_valid)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic rw, input logic [4:0] wa, input logic [2:0] sel,
                       input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] mem,
                       input logic [31:0] hilo, input logic [31:0] cp0, input logic [2:0] lt);
    m_reg_write = rw; m_wa = wa; m_wd_sel = sel; m_pc = pc; m_alu_out = alu;
    m_mem_rdata = mem; m_hilo = hilo; m_cp0_rdata = cp0; m_load_type = lt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; flush = 1'b0;
    drive(1'b1, 5'd9, 3'd2, 32'hABCD_0000, 32'h5555_AAAA, 32'h1, 32'h2, 32'h3, 3'd2);
    step(); step();
    checks++; if (w_reg_write !== 1'b0) begin errors++; $display("FAIL reset_rw got %b exp 0", w_reg_write); end
    checks++; if (w_wa !== 5'd0) begin errors++; $display("FAIL reset_wa got %0d exp 0", w_wa); end
    checks++; if (w_wd !== 32'h0) begin errors++; $display("FAIL reset_wd got %h exp 00000000", w_wd); end
    checks++; if (w_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 00000000", w_pc); end
    checks++; if (w_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", w_valid); end
    reset = 1'b0;
  endtask

  task automatic test_alu_link();
    drive(1'b1, 5'd5, 3'd0, 32'h0000_3000, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 3'd0);
    step();
    checks++; if (w_reg_write !== 1'b1) begin errors++; $display("FAIL alu_rw got %b exp 1", w_reg_write); end
    checks++; if (w_wa !== 5'd5) begin errors++; $display("FAIL alu_wa got %0d exp 5", w_wa); end
    checks++; if (w_wd !== 32'h1234_5678) begin errors++; $display("FAIL alu_wd got %h exp 12345678", w_wd); end
    checks++; if (w_pc !== 32'h0000_3000) begin errors++; $display("FAIL alu_pc got %h exp 00003000", w_pc); end
    checks++; if (w_valid !== 1'b1) begin errors++; $display("FAIL alu_valid got %b exp 1", w_valid); end
    drive(1'b1, 5'd31, 3'd2, 32'hFFFF_FFFC, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 3'd0);
    step();
    checks++; if (w_wd !== 32'h0000_0004) begin errors++; $display("FAIL link_wrap_wd got %h exp 00000004", w_wd); end
    checks++; if (w_wa !== 5'd31) begin errors++; $display("FAIL link_wa got %0d exp 31", w_wa); end
    drive(1'b1, 5'd31, 3'd2, 32'h0000_1000, 32'h0, 32'h0, 32'h0, 32'h0, 3'd0);
    step();
    checks++; if (w_wd !== 32'h0000_1008) begin errors++; $display("FAIL link_wd got %h exp 00001008", w_wd); end
  endtask

  task automatic test_loads();
    logic [31:0] exp_lb, exp_lbu, exp_lh, exp_lhu;
`ifdef SUBWORD_LOAD_EN
    exp_lb = 32'hFFFF_FF80; exp_lbu = 32'h0000_00FF; exp_lh = 32'hFFFF_80FF; exp_lhu = 32'h0000_7F01;
`else
    exp_lb = 32'h80FF_7F01; exp_lbu = 32'h80FF_7F01; exp_lh = 32'h80FF_7F01; exp_lhu = 32'h80FF_7F01;
`endif
    drive(1'b1, 5'd8, 3'd1, 32'h40, 32'h0000_1003, 32'h80FF_7F01, 32'h0, 32'h0, 3'd2);
    step();
    checks++; if (w_wd !== exp_lb) begin errors++; $display("FAIL load_lb got %h exp %h", w_wd, exp_lb); end
    drive(1'b1, 5'd8, 3'd1, 32'h44, 32'h0000_1002, 32'h80FF_7F01, 32'h0, 32'h0, 3'd1);
    step();
    checks++; if (w_wd !== exp_lbu) begin errors++; $display("FAIL load_lbu got %h exp %h", w_wd, exp_lbu); end
    drive(1'b1, 5'd8, 3'd1, 32'h48, 32'h0000_1002, 32'h80FF_7F01, 32'h0, 32'h0, 3'd4);
    step();
    checks++; if (w_wd !== exp_lh) begin errors++; $display("FAIL load_lh got %h exp %h", w_wd, exp_lh); end
    drive(1'b1, 5'd8, 3'd1, 32'h4C, 32'h0000_1000, 32'h80FF_7F01, 32'h0, 32'h0, 3'd3);
    step();
    checks++; if (w_wd !== exp_lhu) begin errors++; $display("FAIL load_lhu got %h exp %h", w_wd, exp_lhu); end
    drive(1'b1, 5'd8, 3'd1, 32'h50, 32'h0000_1003, 32'h80FF_7F01, 32'h0, 32'h0, 3'd0);
    step();
    checks++; if (w_wd !== 32'h80FF_7F01) begin errors++; $display("FAIL load_lw got %h exp 80ff7f01", w_wd); end
  endtask

  task automatic test_zero_reg();
    drive(1'b1, 5'd0, 3'd0, 32'h60, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 3'd0);
    step();
    checks++; if (w_reg_write !== 1'b0) begin errors++; $display("FAIL zero_rw got %b exp 0", w_reg_write); end
    checks++; if (w_wa !== 5'd0) begin errors++; $display("FAIL zero_wa got %0d exp 0", w_wa); end
    checks++; if (w_wd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL zero_wd got %h exp deadbeef", w_wd); end
    checks++; if (w_valid !== 1'b1) begin errors++; $display("FAIL zero_valid got %b exp 1", w_valid); end
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 5'd7, 3'd0, 32'h0000_0100, 32'h0000_0077, 32'h0, 32'h0, 32'h0, 3'd0);
    step();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 5'(10 + i), 3'd3, 32'h200 + 32'(i), 32'h0, 32'h0, 32'hCAFE_0000 + 32'(i), 32'h0, 3'd0);
      step();
      checks++;
      if (w_reg_write !== 1'b1 || w_wa !== 5'd7 || w_wd !== 32'h77 || w_pc !== 32'h100 || w_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold_%0d got rw=%b wa=%0d wd=%h pc=%h v=%b exp rw=1 wa=7 wd=00000077 pc=00000100 v=1",
                 i, w_reg_write, w_wa, w_wd, w_pc, w_valid);
      end
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (w_reg_write !== 1'b0) begin errors++; $display("FAIL flush_rw got %b exp 0", w_reg_write); end
    checks++; if (w_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", w_valid); end
    checks++; if (w_pc !== 32'h0) begin errors++; $display("FAIL flush_pc got %h exp 00000000", w_pc); end
    checks++; if (w_wa !== 5'd0 || w_wd !== 32'h0) begin errors++; $display("FAIL flush_data got wa=%0d wd=%h exp 0/00000000", w_wa, w_wd); end
    en = 1'b1;
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 5'd12, 3'd4, 32'h0000_0300, 32'h0, 32'h0, 32'h0, 32'h0BAD_F00D, 3'd0);
    step();
    checks++; if (w_wd !== 32'h0BAD_F00D) begin errors++; $display("FAIL cp0_wd got %h exp 0badf00d", w_wd); end
    en = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (w_reg_write !== 1'b0 || w_wa !== 5'd0 || w_wd !== 32'h0 || w_pc !== 32'h0 || w_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_stall got rw=%b wa=%0d wd=%h pc=%h v=%b exp all zero", w_reg_write, w_wa, w_wd, w_pc, w_valid);
    end
    en = 1'b1;
  endtask

  task automatic test_select();
    drive(1'b1, 5'd3, 3'd6, 32'h70, 32'hFFFF_0000, 32'h0, 32'h1, 32'h2, 3'd0);
    step();
    checks++; if (w_wd !== 32'h0) begin errors++; $display("FAIL sel6_wd got %h exp 00000000", w_wd); end
    drive(1'b1, 5'd3, 3'd3, 32'h74, 32'hFFFF_0000, 32'h0, 32'h1, 32'h2, 3'd0);
    step();
    checks++; if (w_wd !== 32'h1) begin errors++; $display("FAIL sel_hilo_wd got %h exp 00000001", w_wd); end
    drive(1'b1, 5'd3, 3'd5, 32'h78, 32'hFFFF_0000, 32'h0, 32'h1, 32'h2, 3'd0);
    step();
    checks++; if (w_wd !== 32'h0) begin errors++; $display("FAIL sel5_wd got %h exp 00000000", w_wd); end
    drive(1'b1, 5'd3, 3'd7, 32'h7C, 32'hFFFF_0000, 32'h0, 32'h1, 32'h2, 3'd0);
    step();
    checks++; if (w_wd !== 32'h0) begin errors++; $display("FAIL sel7_wd got %h exp 00000000", w_wd); end
  endtask

  initial begin
    test_reset();
    test_alu_link();
    test_loads();
    test_zero_reg();
    test_stall_flush();
    test_reset_mid_stall();
    test_select();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
